// File: rtl/axi_mem_pkg.sv
// Shared types and helpers for the AXI-to-memory-helper bridge.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'd0,
    BurstIncr  = 2'd1,
    BurstWrap  = 2'd2
  } burst_t;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  typedef enum logic {
    RIdle,
    RBurst
  } rd_state_t;

  typedef enum logic [1:0] {
    WIdle,
    WData,
    WResp
  } wr_state_t;

  // One R FIFO slot: beat data, last flag and response code.
  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [1:0]  resp;
  } r_entry_t;

  // Expand an 8-bit byte strobe to a 64-bit bit mask.
  function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
    logic [63:0] mask;
    for (int k = 0; k < 8; k++) begin
      mask[8*k +: 8] = {8{strb[k]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP AXI bursts.
module axi_burst_addr_gen
  import axi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] wrap_mask;

  // WRAP keeps the upper bits of the aligned window and wraps the offset inside it.
  always_comb begin
    step      = ADDR_W'(1) << size;
    incr      = addr + step;
    wrap_mask = (ADDR_W'({1'b0, len} + 9'd1) << size) - ADDR_W'(1);
    case (burst)
      BurstFixed: next_addr = addr;
      BurstWrap:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:    next_addr = incr;  // INCR, and reserved burst 3 behaves as INCR
    endcase
  end

endmodule

// File: rtl/axi_mem_rw_bridge.sv
// AXI4 slave turning read/write bursts into single-beat 64-bit memory helper accesses.
module axi_mem_rw_bridge
  import axi_mem_pkg::*;
#(
  parameter int unsigned ID_W      = 4,
  parameter int unsigned ADDR_W    = 64,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MEM_WORDS = 64'd536870912
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ID_W-1:0]   aw_id,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [7:0]        aw_len,
  input  logic [2:0]        aw_size,
  input  logic [1:0]        aw_burst,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [63:0]       w_data,
  input  logic [7:0]        w_strb,
  input  logic              w_last,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [ID_W-1:0]   b_id,
  output logic [1:0]        b_resp,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [7:0]        ar_len,
  input  logic [2:0]        ar_size,
  input  logic [1:0]        ar_burst,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [ID_W-1:0]   r_id,
  output logic [63:0]       r_data,
  output logic [1:0]        r_resp,
  output logic              r_last,
  output logic              mem_r_enable,
  output logic [63:0]       mem_r_index,
  input  logic [63:0]       mem_r_data,
  output logic              mem_w_enable,
  output logic [63:0]       mem_w_index,
  output logic [63:0]       mem_w_data,
  output logic [63:0]       mem_w_mask,
  output logic              mem_enable
);

  function automatic logic [63:0] word_index(input logic [ADDR_W-1:0] a);
    return (64'(a) - BASE_ADDR) >> 3;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (64'(a) >= BASE_ADDR) && (word_index(a) < MEM_WORDS);
  endfunction

  logic en_q;

  // Read path state
  rd_state_t         rd_state_q, rd_state_d;
  logic [ID_W-1:0]   rd_id_q;
  logic [ADDR_W-1:0] rd_addr_q, rd_next_addr;
  logic [7:0]        rd_len_q, rd_beat_q;
  logic [2:0]        rd_size_q;
  logic [1:0]        rd_burst_q;
  logic              ar_hs, rd_issue, rd_credit, rd_in_range, rd_last_beat;
  logic [2:0]        rd_occ;
  logic              pend_q, pend_oor_q, pend_last_q;
  logic [ID_W-1:0]   pend_id_q;
  r_entry_t          fifo_q [2];
  logic [ID_W-1:0]   fifo_id_q [2];
  logic              fifo_wptr_q, fifo_rptr_q;
  logic [1:0]        fifo_cnt_q;
  logic              r_pop;
  r_entry_t          push_entry;

  // Write path state
  wr_state_t         wr_state_q, wr_state_d;
  logic [ID_W-1:0]   wr_id_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_next_addr;
  logic [7:0]        wr_len_q, wr_beat_q;
  logic [2:0]        wr_size_q;
  logic [1:0]        wr_burst_q;
  logic [1:0]        wr_resp_q;
  logic              aw_hs, w_hs, wr_in_range, wr_count_last, wr_done;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr_gen (
    .addr      (rd_addr_q),
    .size      (rd_size_q),
    .len       (rd_len_q),
    .burst     (rd_burst_q),
    .next_addr (rd_next_addr)
  );

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr_gen (
    .addr      (wr_addr_q),
    .size      (wr_size_q),
    .len       (wr_len_q),
    .burst     (wr_burst_q),
    .next_addr (wr_next_addr)
  );

  // Memory enable: low through reset, high from the first cycle after it.
  always_ff @(posedge clock) begin
    if (reset) en_q <= 1'b0;
    else       en_q <= 1'b1;
  end

  assign mem_enable = en_q;

  // ---------------------------------------------------------------- read path

  // Read FSM state register.
  always_ff @(posedge clock) begin
    if (reset) rd_state_q <= RIdle;
    else       rd_state_q <= rd_state_d;
  end

  // R FIFO head, pop and issue credit; a same-cycle pop frees a slot for the next issue.
  always_comb begin
    r_valid   = (fifo_cnt_q != 2'd0);
    r_data    = fifo_q[fifo_rptr_q].data;
    r_last    = fifo_q[fifo_rptr_q].last;
    r_resp    = fifo_q[fifo_rptr_q].resp;
    r_id      = fifo_id_q[fifo_rptr_q];
    r_pop     = r_valid && r_ready;
    rd_occ    = {1'b0, fifo_cnt_q} + {2'b00, pend_q} - {2'b00, r_pop};
    rd_credit = (rd_occ < 3'd2);
  end

  // Read FSM outputs: AR acceptance and per-beat memory strobe.
  always_comb begin
    ar_ready     = en_q && (rd_state_q == RIdle);
    ar_hs        = ar_valid && ar_ready;
    rd_in_range  = in_range(rd_addr_q);
    rd_last_beat = (rd_beat_q == rd_len_q);
    rd_issue     = (rd_state_q == RBurst) && rd_credit;
    mem_r_enable = rd_issue && rd_in_range;
    mem_r_index  = mem_r_enable ? word_index(rd_addr_q) : 64'd0;
  end

  // Read FSM next state.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RIdle:   if (ar_hs) rd_state_d = RBurst;
      RBurst:  if (rd_issue && rd_last_beat) rd_state_d = RIdle;
      default: rd_state_d = RIdle;
    endcase
  end

  // Read burst context and one-deep pipeline tracking the read in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_id_q     <= '0;
      rd_addr_q   <= '0;
      rd_len_q    <= '0;
      rd_size_q   <= '0;
      rd_burst_q  <= '0;
      rd_beat_q   <= '0;
      pend_q      <= 1'b0;
      pend_oor_q  <= 1'b0;
      pend_last_q <= 1'b0;
      pend_id_q   <= '0;
    end else begin
      if (ar_hs) begin
        rd_id_q    <= ar_id;
        rd_addr_q  <= ar_addr;
        rd_len_q   <= ar_len;
        rd_size_q  <= ar_size;
        rd_burst_q <= ar_burst;
        rd_beat_q  <= '0;
      end else if (rd_issue) begin
        rd_addr_q <= rd_next_addr;
        rd_beat_q <= rd_beat_q + 8'd1;
      end
      pend_q      <= rd_issue;
      pend_oor_q  <= !rd_in_range;
      pend_last_q <= rd_last_beat;
      pend_id_q   <= rd_id_q;
    end
  end

  // Out-of-range beats take a FIFO slot too so response order is preserved.
  always_comb begin
    push_entry.data = pend_oor_q ? 64'd0 : mem_r_data;
    push_entry.last = pend_last_q;
    push_entry.resp = pend_oor_q ? RespDecerr : RespOkay;
  end

  // Two-entry R FIFO storage and pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        fifo_q[i]    <= '0;
        fifo_id_q[i] <= '0;
      end
      fifo_wptr_q <= 1'b0;
      fifo_rptr_q <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      if (pend_q) begin
        fifo_q[fifo_wptr_q]    <= push_entry;
        fifo_id_q[fifo_wptr_q] <= pend_id_q;
        fifo_wptr_q            <= ~fifo_wptr_q;
      end
      if (r_pop) fifo_rptr_q <= ~fifo_rptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, pend_q} - {1'b0, r_pop};
    end
  end

  // --------------------------------------------------------------- write path

  // Write FSM state register.
  always_ff @(posedge clock) begin
    if (reset) wr_state_q <= WIdle;
    else       wr_state_q <= wr_state_d;
  end

  // Write FSM outputs: handshakes, B channel and memory write pass-through.
  always_comb begin
    aw_ready      = en_q && (wr_state_q == WIdle);
    w_ready       = (wr_state_q == WData);
    b_valid       = (wr_state_q == WResp);
    b_id          = wr_id_q;
    b_resp        = wr_resp_q;
    aw_hs         = aw_valid && aw_ready;
    w_hs          = w_valid && w_ready;
    wr_in_range   = in_range(wr_addr_q);
    wr_count_last = (wr_beat_q == wr_len_q);
    wr_done       = w_hs && (w_last || wr_count_last);
    mem_w_enable  = w_hs && wr_in_range;
    mem_w_index   = mem_w_enable ? word_index(wr_addr_q) : 64'd0;
    mem_w_data    = mem_w_enable ? w_data : 64'd0;
    mem_w_mask    = mem_w_enable ? strb_to_mask(w_strb) : 64'd0;
  end

  // Write FSM next state.
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WIdle:   if (aw_hs) wr_state_d = WData;
      WData:   if (wr_done) wr_state_d = WResp;
      WResp:   if (b_ready) wr_state_d = WIdle;
      default: wr_state_d = WIdle;
    endcase
  end

  // Write burst context and accumulated response; DECERR outranks SLVERR.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_id_q    <= '0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_size_q  <= '0;
      wr_burst_q <= '0;
      wr_beat_q  <= '0;
      wr_resp_q  <= RespOkay;
    end else if (aw_hs) begin
      wr_id_q    <= aw_id;
      wr_addr_q  <= aw_addr;
      wr_len_q   <= aw_len;
      wr_size_q  <= aw_size;
      wr_burst_q <= aw_burst;
      wr_beat_q  <= '0;
      wr_resp_q  <= RespOkay;
    end else if (w_hs) begin
      wr_addr_q <= wr_next_addr;
      wr_beat_q <= wr_beat_q + 8'd1;
      if ((wr_resp_q == RespDecerr) || !wr_in_range) begin
        wr_resp_q <= RespDecerr;
      end else if (wr_done && (w_last != wr_count_last)) begin
        wr_resp_q <= RespSlverr;
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_rw_bridge.sv
// Directed self-checking bench for axi_mem_rw_bridge with a small word memory model.
module tb_axi_mem_rw_bridge;

  logic        clock, reset;
  logic        aw_valid, aw_ready;
  logic [3:0]  aw_id;
  logic [63:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        b_valid, b_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_id;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        mem_r_enable, mem_w_enable, mem_enable;
  logic [63:0] mem_r_index, mem_r_data, mem_w_index, mem_w_data, mem_w_mask;

  axi_mem_rw_bridge dut (
    .clock(clock), .reset(reset),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last),
    .mem_r_enable(mem_r_enable), .mem_r_index(mem_r_index), .mem_r_data(mem_r_data),
    .mem_w_enable(mem_w_enable), .mem_w_index(mem_w_index), .mem_w_data(mem_w_data),
    .mem_w_mask(mem_w_mask), .mem_enable(mem_enable)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory model: 64 words preset to A000..0000 | index; beyond that reads return FFFF..|index.
  logic [63:0] mem [64];
  bit          mem_init;
  int          cyc;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 64'hA000_0000_0000_0000 | 64'(i);
      mem_init <= 1'b1;
    end else if (mem_w_enable && mem_w_index < 64) begin
      mem[mem_w_index[5:0]] <= (mem[mem_w_index[5:0]] & ~mem_w_mask) | (mem_w_data & mem_w_mask);
    end
    if (mem_r_enable) begin
      mem_r_data <= (mem_r_index < 64) ? mem[mem_r_index[5:0]]
                                       : (64'hFFFF_0000_0000_0000 | mem_r_index);
    end
  end

  // Observation queues, sampled on the falling edge.
  logic [63:0] ri_idx_q[$];
  int          ri_cyc_q[$];
  logic [63:0] rd_data_q[$];
  logic [1:0]  rd_resp_q[$];
  logic        rd_last_q[$];
  logic [3:0]  rd_id_q[$];
  logic [63:0] wi_idx_q[$];
  logic [63:0] wi_data_q[$];
  logic [63:0] wi_mask_q[$];

  always @(negedge clock) begin
    if (mem_r_enable) begin
      ri_idx_q.push_back(mem_r_index);
      ri_cyc_q.push_back(cyc);
    end
    if (r_valid && r_ready) begin
      rd_data_q.push_back(r_data);
      rd_resp_q.push_back(r_resp);
      rd_last_q.push_back(r_last);
      rd_id_q.push_back(r_id);
    end
    if (mem_w_enable) begin
      wi_idx_q.push_back(mem_w_index);
      wi_data_q.push_back(mem_w_data);
      wi_mask_q.push_back(mem_w_mask);
    end
  end

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_ar(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    logic hs;
    hs = 1'b0;
    ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clock);
      hs = ar_ready;
      tick();
    end
    ar_valid = 1'b0;
    check("ar_accept", 64'(hs), 64'd1);
  endtask

  task automatic send_aw(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    logic hs;
    hs = 1'b0;
    aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_id = id;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clock);
      hs = aw_ready;
      tick();
    end
    aw_valid = 1'b0;
    check("aw_accept", 64'(hs), 64'd1);
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    logic hs;
    hs = 1'b0;
    w_valid = 1'b1; w_data = data; w_strb = strb; w_last = last;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clock);
      hs = w_ready;
      tick();
    end
    w_valid = 1'b0; w_last = 1'b0;
    check("w_accept", 64'(hs), 64'd1);
  endtask

  task automatic wait_b(input string tag, input logic [1:0] exp_resp, input logic [3:0] exp_id);
    logic seen;
    seen = 1'b0;
    b_ready = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (b_valid) begin
        seen = 1'b1;
        check({tag, "_bresp"}, 64'(b_resp), 64'(exp_resp));
        check({tag, "_bid"}, 64'(b_id), 64'(exp_id));
      end
      tick();
    end
    b_ready = 1'b0;
    check({tag, "_bvalid"}, 64'(seen), 64'd1);
  endtask

  task automatic wait_r(input string tag, input int target);
    r_ready = 1'b1;
    for (int i = 0; i < 200 && rd_data_q.size() < target; i++) tick();
    check({tag, "_rcount"}, 64'(rd_data_q.size() >= target), 64'd1);
  endtask

  int rb, ib, wb, outstanding, max_out;

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1;
    aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0; r_ready = 0;
    repeat (3) tick();

    // Reset values
    check("rst_ar_ready", 64'(ar_ready), 64'd0);
    check("rst_aw_ready", 64'(aw_ready), 64'd0);
    check("rst_w_ready", 64'(w_ready), 64'd0);
    check("rst_b_valid", 64'(b_valid), 64'd0);
    check("rst_r_valid", 64'(r_valid), 64'd0);
    check("rst_mem_enable", 64'(mem_enable), 64'd0);
    check("rst_mem_r_en", 64'(mem_r_enable), 64'd0);
    check("rst_mem_w_en", 64'(mem_w_enable), 64'd0);
    check("rst_mem_w_mask", mem_w_mask, 64'd0);
    check("rst_r_resp", 64'(r_resp), 64'd0);
    check("rst_b_resp", 64'(b_resp), 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_mem_enable", 64'(mem_enable), 64'd1);
    check("post_rst_ar_ready", 64'(ar_ready), 64'd1);

    // 1. INCR read of four words at full rate
    rb = rd_data_q.size(); ib = ri_idx_q.size();
    r_ready = 1'b1;
    send_ar(64'h8000_0000, 8'd3, 3'd3, 2'd1, 4'h5);
    wait_r("t1", rb + 4);
    check("t1_nissue", 64'(ri_idx_q.size() - ib), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_idx%0d", k), ri_idx_q[ib+k], 64'(k));
      check($sformatf("t1_cyc%0d", k), 64'(ri_cyc_q[ib+k] - ri_cyc_q[ib]), 64'(k));
      check($sformatf("t1_data%0d", k), rd_data_q[rb+k], 64'hA000_0000_0000_0000 | 64'(k));
      check($sformatf("t1_last%0d", k), 64'(rd_last_q[rb+k]), 64'(k == 3));
      check($sformatf("t1_id%0d", k), 64'(rd_id_q[rb+k]), 64'h5);
    end

    // 2. WRAP write starting at index 3
    wb = wi_idx_q.size();
    send_aw(64'h8000_0018, 8'd3, 3'd3, 2'd2, 4'h9);
    for (int k = 0; k < 4; k++) send_w(64'hC0DE_0000_0000_0000 + 64'(k), 8'hFF, k == 3);
    wait_b("t2", 2'b00, 4'h9);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_idx%0d", k), wi_idx_q[wb+k], 64'((k + 3) % 4));
    end

    // 3. Partial strobe single write to index 5
    wb = wi_idx_q.size();
    send_aw(64'h8000_0028, 8'd0, 3'd3, 2'd1, 4'h2);
    send_w(64'h1122_3344_5566_7788, 8'b0000_0101, 1'b1);
    wait_b("t3", 2'b00, 4'h2);
    check("t3_idx", wi_idx_q[wb], 64'd5);
    check("t3_mask", wi_mask_q[wb], 64'h0000_0000_00FF_00FF);
    check("t3_data", wi_data_q[wb], 64'h1122_3344_5566_7788);

    // Read back indices 3..5 to see the writes landed
    rb = rd_data_q.size();
    send_ar(64'h8000_0018, 8'd2, 3'd3, 2'd1, 4'h1);
    wait_r("rb", rb + 3);
    check("rb_idx3", rd_data_q[rb], 64'hC0DE_0000_0000_0000);
    check("rb_idx4", rd_data_q[rb+1], 64'hA000_0000_0000_0004);
    check("rb_idx5", rd_data_q[rb+2], 64'hA000_0000_0066_0088);

    // 4. Eight-beat read with r_ready toggling every two cycles
    rb = rd_data_q.size(); ib = ri_idx_q.size();
    r_ready = 1'b0;
    send_ar(64'h8000_0040, 8'd7, 3'd3, 2'd1, 4'hA);
    max_out = 0;
    for (int k = 0; k < 400 && rd_data_q.size() < rb + 8; k++) begin
      r_ready = ((k / 2) % 2) == 0;
      tick();
      outstanding = (ri_idx_q.size() - ib) - (rd_data_q.size() - rb);
      if (outstanding > max_out) max_out = outstanding;
    end
    check("t4_count", 64'(rd_data_q.size() - rb), 64'd8);
    check("t4_max_out_le2", 64'(max_out <= 2), 64'd1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t4_data%0d", k), rd_data_q[rb+k], 64'hA000_0000_0000_0000 | 64'(8 + k));
      check($sformatf("t4_last%0d", k), 64'(rd_last_q[rb+k]), 64'(k == 7));
    end

    // 5. Range: below base, last valid word, one past the end
    rb = rd_data_q.size(); ib = ri_idx_q.size();
    send_ar(64'h7FFF_FFF8, 8'd0, 3'd3, 2'd1, 4'h3);
    wait_r("t5lo", rb + 1);
    check("t5lo_nostrobe", 64'(ri_idx_q.size() - ib), 64'd0);
    check("t5lo_data", rd_data_q[rb], 64'd0);
    check("t5lo_resp", 64'(rd_resp_q[rb]), 64'h3);
    check("t5lo_last", 64'(rd_last_q[rb]), 64'd1);
    rb = rd_data_q.size(); ib = ri_idx_q.size();
    send_ar(64'h1_7FFF_FFF8, 8'd0, 3'd3, 2'd1, 4'h4);
    wait_r("t5top", rb + 1);
    check("t5top_idx", ri_idx_q[ib], 64'h1FFF_FFFF);
    check("t5top_data", rd_data_q[rb], 64'hFFFF_0000_1FFF_FFFF);
    check("t5top_resp", 64'(rd_resp_q[rb]), 64'h0);
    wb = wi_idx_q.size();
    send_aw(64'h1_8000_0000, 8'd0, 3'd3, 2'd1, 4'h7);
    send_w(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b1);
    wait_b("t5w", 2'b11, 4'h7);
    check("t5w_nostrobe", 64'(wi_idx_q.size() - wb), 64'd0);

    // w_last arrives before len is reached
    wb = wi_idx_q.size();
    send_aw(64'h8000_0030, 8'd1, 3'd3, 2'd1, 4'hB);
    send_w(64'h5555_5555_5555_5555, 8'hFF, 1'b1);
    wait_b("slv", 2'b10, 4'hB);
    check("slv_idx", wi_idx_q[wb], 64'd6);

    // 6. Reset in the middle of an eight-beat read
    ib = ri_idx_q.size();
    r_ready = 1'b1;
    send_ar(64'h8000_0000, 8'd7, 3'd3, 2'd1, 4'h6);
    for (int i = 0; i < 50 && ri_idx_q.size() < ib + 2; i++) tick();
    reset = 1'b1;
    tick();
    check("t6_r_valid", 64'(r_valid), 64'd0);
    check("t6_mem_r_en", 64'(mem_r_enable), 64'd0);
    check("t6_mem_r_idx", mem_r_index, 64'd0);
    check("t6_ar_ready", 64'(ar_ready), 64'd0);
    check("t6_mem_enable", 64'(mem_enable), 64'd0);
    check("t6_b_valid", 64'(b_valid), 64'd0);
    rb = rd_data_q.size();
    reset = 1'b0;
    repeat (3) tick();
    check("t6_no_stale", 64'(rd_data_q.size() - rb), 64'd0);
    send_ar(64'h8000_0080, 8'd1, 3'd3, 2'd1, 4'hC);
    wait_r("t6", rb + 2);
    check("t6_data0", rd_data_q[rb], 64'hA000_0000_0000_0010);
    check("t6_data1", rd_data_q[rb+1], 64'hA000_0000_0000_0011);
    check("t6_last0", 64'(rd_last_q[rb]), 64'd0);
    check("t6_last1", 64'(rd_last_q[rb+1]), 64'd1);
    check("t6_id", 64'(rd_id_q[rb+1]), 64'hC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
